mux_from_rs2_ie_to_alu: RTL and testbench

//  ALU operand-B select for the single-cycle RV32 datapath: picks rs2 read data,
//  the immediate-extender (IE) output, or the constant 4, under decoder control
//  mrs2andie_ctr. The main output mrs2andie_out is combinational, driving the ALU
//  in the same cycle. A registered copy and a sticky illegal-select flag serve

---
 rtl/mux_from_rs2_ie_to_alu.sv | 53 +++++
 tb/tb_mux_from_rs2_ie_to_alu.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mux_from_rs2_ie_to_alu.sv
// rtl/mux_from_rs2_ie_to_alu.sv - ALU operand-B select (rs2 / imm / 4) with registered copy and sticky illegal-select flag
// Optional feature macro: MRS2ANDIE_SHAMT_EN (select 11 yields imm[4:0] and is legal)
module mux_from_rs2_ie_to_alu #(
   parameter int          WIDTH      = 32,
   parameter int unsigned CONST_FOUR = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mrs2andie_ctr,
   input  logic [WIDTH-1:0] rs2,
   input  logic [WIDTH-1:0] imm,
   output logic [WIDTH-1:0] mrs2andie_out,
   output logic [WIDTH-1:0] mrs2andie_q,
   output logic             sel_err
);

`ifdef MRS2ANDIE_SHAMT_EN
   localparam logic SEL11_ILLEGAL = 1'b0;
`else
   localparam logic SEL11_ILLEGAL = 1'b1;
`endif

   localparam logic [WIDTH-1:0] FOUR = WIDTH'(CONST_FOUR);

   // Unknown select bits fall to the default arm, so X/Z never leaks onto the ALU.
   always_comb begin
      mrs2andie_out = '0;
      case (mrs2andie_ctr)
         2'b00:   mrs2andie_out = rs2;
         2'b01:   mrs2andie_out = imm;
         2'b10:   mrs2andie_out = FOUR;
`ifdef MRS2ANDIE_SHAMT_EN
         2'b11:   mrs2andie_out = {{(WIDTH-5){1'b0}}, imm[4:0]};
`else
         2'b11:   mrs2andie_out = '0;
`endif
         default: mrs2andie_out = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mrs2andie_q <= '0;
         sel_err     <= 1'b0;
      end else if (en) begin
         mrs2andie_q <= mrs2andie_out;
         if (SEL11_ILLEGAL && (mrs2andie_ctr == 2'b11))
            sel_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mux_from_rs2_ie_to_alu.sv
// tb/tb_mux_from_rs2_ie_to_alu.sv - self-checking bench for mux_from_rs2_ie_to_alu
module tb_mux_from_rs2_ie_to_alu;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [1:0]  ctr;
   logic [31:0] rs2;
   logic [31:0] imm;
   logic [31:0] out_w;
   logic [31:0] q_w;
   logic        err_w;

   int checks = 0;
   int errors = 0;
   bit clk_on = 0;
   bit chk_on = 0;

   logic [31:0] m_q;
   logic        m_err;

   mux_from_rs2_ie_to_alu #(.WIDTH(32), .CONST_FOUR(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .en            (en),
      .mrs2andie_ctr (ctr),
      .rs2           (rs2),
      .imm           (imm),
      .mrs2andie_out (out_w),
      .mrs2andie_q   (q_w),
      .sel_err       (err_w)
   );

   initial begin
      clk = 0;
      wait (clk_on);
      forever #5 clk = ~clk;
   end

   // Operand table indexed by select: what the ALU must see for each code.
   function automatic logic [31:0] ref_out(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] tbl [4];
      tbl[0] = a;
      tbl[1] = b;
      tbl[2] = 32'd4;
`ifdef MRS2ANDIE_SHAMT_EN
      tbl[3] = b % 32;
`else
      tbl[3] = 32'd0;
`endif
      return tbl[c];
   endfunction

   function automatic bit ref_illegal(input logic [1:0] c);
`ifdef MRS2ANDIE_SHAMT_EN
      return 1'b0;
`else
      return c == 2'd3;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q   = 32'd0;
         m_err = 1'b0;
      end else if (en) begin
         m_q = ref_out(ctr, rs2, imm);
         if (ref_illegal(ctr)) m_err = 1'b1;
      end
   end

   always @(posedge clk) begin
      #1;
      if (chk_on) begin
         chk("model_out", out_w, ref_out(ctr, rs2, imm));
         chk("model_q", q_w, m_q);
         chk("model_err", {31'd0, err_w}, {31'd0, m_err});
      end
   end

   initial begin
      rst_n = 1; en = 0; ctr = 2'b00; rs2 = 32'h1; imm = 32'h2;
      #1 chk("t1_out_rs2", out_w, 32'h1);
      #9 ctr = 2'b01;
      #1 chk("t2_out_imm", out_w, 32'h2);
      #9 ctr = 2'b10;
      #1 chk("t2_out_four", out_w, 32'h4);
      #4 rst_n = 0;
      #1 chk("rst_q", q_w, 32'h0);
      chk("rst_err", {31'd0, err_w}, 32'h0);
      #4 rst_n = 1;
      clk_on = 1;
      chk_on = 1;

      @(negedge clk);
      en = 1; ctr = 2'b01; imm = 32'hDEAD_BEEF;
      @(posedge clk); #1 chk("t4_q_capture", q_w, 32'hDEAD_BEEF);
      @(negedge clk);
      en = 0; ctr = 2'b00; rs2 = 32'h1234_5678;
      @(posedge clk); #1 chk("t4_q_hold", q_w, 32'hDEAD_BEEF);

      @(negedge clk);
      ctr = 2'b11; imm = 32'hFFFF_FFE3;
`ifdef MRS2ANDIE_SHAMT_EN
      #1 chk("t3_out_sel11", out_w, 32'h3);
`else
      #1 chk("t3_out_sel11", out_w, 32'h0);
`endif
      en = 1;
      @(posedge clk); #1;
`ifdef MRS2ANDIE_SHAMT_EN
      chk("t3_err_set", {31'd0, err_w}, 32'h0);
`else
      chk("t3_err_set", {31'd0, err_w}, 32'h1);
`endif
      @(negedge clk);
      ctr = 2'b00; en = 1;
      @(posedge clk); #1;
`ifdef MRS2ANDIE_SHAMT_EN
      chk("t3_err_sticky", {31'd0, err_w}, 32'h0);
`else
      chk("t3_err_sticky", {31'd0, err_w}, 32'h1);
`endif
      chk("t3_q_after", q_w, 32'h1234_5678);

      @(negedge clk);
      #2 rst_n = 0;
      #1 chk("t5_q_async", q_w, 32'h0);
      chk("t5_err_async", {31'd0, err_w}, 32'h0);
      rs2 = 32'h0000_0055; ctr = 2'b00;
      #1 chk("t5_out_in_reset", out_w, 32'h55);
      ctr = 2'b10;
      #1 chk("t5_out_four_in_reset", out_w, 32'h4);
      @(negedge clk);
      rst_n = 1;

      repeat (1000) begin
         @(negedge clk);
         ctr = 2'($urandom_range(0, 3));
         rs2 = $urandom;
         imm = $urandom;
         en  = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #2;
      chk_on = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
